svm_mac_sched: RTL and testbench
================================

SVM_MAC_SCHED -- requirements
Module: svm_mac_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the IEEE-754 single operand/result width (from the shared package).
REQ-002 SHALL have parameter FEAT_AW, default 6, meaning the feature address width (max 64 features).
REQ-003 SHALL have parameter SV_AW, default 8, meaning the support-vector index width (max 256 SVs).
REQ-004 SHALL have parameter TMO_CYC, default 255, meaning the result-wait timeout in cycles.
REQ-005 SHALL have ports as follows; there is one clock, and reset is synchronous and active-high:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  launch a job; sampled only in IDLE
- num_feat  in  FEAT_AW+1  features per vector (1..64); latched on start
- num_sv  in  SV_AW+1  vectors per job (1..256); latched on start
- op_sel  in  1  passed to mult_op_sel; latched on start
- sv_rd_en  out  1  SV memory read strobe
- sv_rd_addr  out  SV_AW+FEAT_AW  address {sv_idx, feat_idx}
- sv_rd_data  in  DATA_WIDTH  SV memory data, 1 cycle after sv_rd_en
- x_rd_en  out  1  input-vector memory read strobe
- x_rd_addr  out  FEAT_AW  feature address
- x_rd_data  in  DATA_WIDTH  input-vector data, 1 cycle after x_rd_en
- mult_en  out  1  operand pair valid to the multiplier/accumulator
- mult_data_1  out  DATA_WIDTH  SV operand
- mult_data_2  out  DATA_WIDTH  input-vector operand
- mult_op_sel  out  1  latched op_sel
- mult_res  in  DATA_WIDTH  accumulated dot product
- mult_res_vld  in  1  accumulated result valid (1-cycle pulse)
- dot_vld  out  1  one-cycle pulse; dot_data/dot_idx valid
- dot_data  out  DATA_WIDTH  captured mult_res
- dot_idx  out  SV_AW  SV index of dot_data
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at job end
- err_tmo  out  1  sticky timeout flag; cleared by start or rst

Function
REQ-006 The FSM SHALL have states IDLE, FETCH, DRAIN, WAIT_RES, DONE.
REQ-007 In IDLE with start=1, the block SHALL latch num_feat, num_sv and op_sel, clear feat_idx/sv_idx/err_tmo, and enter FETCH on the next cycle.
REQ-008 In FETCH, sv_rd_en and x_rd_en SHALL assert every cycle, with addresses {sv_idx,feat_idx} and feat_idx; feat_idx SHALL increment each cycle.
REQ-009 mult_en SHALL equal the one-cycle-delayed read strobe, with mult_data_1=sv_rd_data and mult_data_2=x_rd_data, giving exactly num_feat mult_en cycles per vector, back to back.
REQ-010 When feat_idx==num_feat-1 is issued in FETCH, the FSM SHALL go to DRAIN; DRAIN SHALL last 1 cycle (the final mult_en) and then go to WAIT_RES.
REQ-011 In WAIT_RES, the timeout counter SHALL increment each cycle; on mult_res_vld, dot_data<=mult_res, dot_idx<=sv_idx and dot_vld pulses on the following cycle.
REQ-012 After a result, if sv_idx==num_sv-1 the FSM SHALL go to DONE, otherwise it SHALL increment sv_idx, clear feat_idx and return to FETCH.
REQ-013 If the counter reaches TMO_CYC without mult_res_vld, err_tmo SHALL set, dot_vld SHALL NOT pulse, and the FSM SHALL go to DONE.
REQ-014 DONE SHALL pulse done for 1 cycle and then return to IDLE.
REQ-015 start SHALL be ignored while busy.
REQ-016 num_feat==0 or num_sv==0 at start SHALL go directly to DONE with no reads.
REQ-017 mult_res_vld outside WAIT_RES SHALL be ignored.
REQ-018 Counters SHALL never wrap: num_feat=64 and num_sv=256 SHALL use full-width compares.

Reset
REQ-019 On rst=1 at a clock edge, the state SHALL become IDLE, all counters 0, and all outputs 0, including mid-job; no further strobes SHALL issue.

Structure
REQ-020 The FSM state enum, DATA_WIDTH, FEAT_AW, SV_AW and TMO_CYC defaults SHALL reside in the shared param package.
REQ-021 The address counter pair SHALL be one sub-module, svm_addr_gen, with inputs clr/inc_feat/inc_sv and outputs feat_idx/sv_idx/last_feat/last_sv.

Verification
REQ-022 The bench SHALL cover num_feat=3, num_sv=2, with a model returning mult_res_vld 4 cycles after the last mult_en -> 6 mult_en cycles in 2 bursts of 3, dot_vld twice with idx 0 then 1, then done, with busy low after done.
REQ-023 The bench SHALL cover SV mem = 1.0 (0x3F800000) and X mem = 2.0 (0x40000000), with mult_data_1/2 matching memory contents and addr {0,0},{0,1},{0,2} in order.
REQ-024 The bench SHALL cover withholding mult_res_vld -> err_tmo=1 after 255 WAIT_RES cycles, done pulse, no dot_vld.
REQ-025 The bench SHALL cover rst asserted during FETCH of SV 1 -> next cycle all strobes 0, state IDLE; a new start then runs from sv_idx 0.
REQ-026 The bench SHALL cover start pulsed while busy, and start with num_feat=0 -> the first is ignored (count unchanged); the second gives done 2 cycles after start with zero reads.
REQ-027 The bench SHALL cover num_feat=64 and num_sv=256 -> 16384 mult_en cycles, last address {255,63}, and 256 dot_vld pulses.

Source files
------------

// File: rtl/svm_mac_sched_pkg.sv
// Shared parameters and FSM state type for the SVM dot-product scheduler.
package svm_mac_sched_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int FEAT_AW_DEF    = 6;
    localparam int SV_AW_DEF      = 8;
    localparam int TMO_CYC_DEF    = 255;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/svm_addr_gen.sv
// Feature / support-vector address counter pair with terminal-index flags.
// Counters only advance below their terminal value, so they never wrap.
module svm_addr_gen #(
    parameter int FEAT_AW = 6,
    parameter int SV_AW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc_feat,
    input  logic               inc_sv,
    input  logic [FEAT_AW:0]   num_feat,
    input  logic [SV_AW:0]     num_sv,
    output logic [FEAT_AW-1:0] feat_idx,
    output logic [SV_AW-1:0]   sv_idx,
    output logic               last_feat,
    output logic               last_sv
);

    localparam logic [FEAT_AW-1:0] FEAT_INC = 1;
    localparam logic [SV_AW-1:0]   SV_INC   = 1;
    localparam logic [FEAT_AW:0]   FEAT_ONE = 1;
    localparam logic [SV_AW:0]     SV_ONE   = 1;

    logic [FEAT_AW-1:0] feat_idx_q, feat_idx_d;
    logic [SV_AW-1:0]   sv_idx_q, sv_idx_d;

    // Next-index selection: clear wins, a new vector resets the feature index.
    always_comb begin
        feat_idx_d = feat_idx_q;
        sv_idx_d   = sv_idx_q;
        if (clr) begin
            feat_idx_d = '0;
            sv_idx_d   = '0;
        end else if (inc_sv) begin
            sv_idx_d   = sv_idx_q + SV_INC;
            feat_idx_d = '0;
        end else if (inc_feat) begin
            feat_idx_d = feat_idx_q + FEAT_INC;
        end
    end

    // Index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            feat_idx_q <= '0;
            sv_idx_q   <= '0;
        end else begin
            feat_idx_q <= feat_idx_d;
            sv_idx_q   <= sv_idx_d;
        end
    end

    assign feat_idx  = feat_idx_q;
    assign sv_idx    = sv_idx_q;
    // Compares are one bit wider than the index so 64 features / 256 SVs work.
    assign last_feat = ({1'b0, feat_idx_q} == (num_feat - FEAT_ONE));
    assign last_sv   = ({1'b0, sv_idx_q} == (num_sv - SV_ONE));

endmodule

// File: rtl/svm_mac_sched.sv
// SVM dot-product scheduler: streams SV/X operand pairs to an external
// multiply-accumulate unit, one vector at a time, and collects each result.
//
// state       | meaning
// ST_IDLE     | waiting for start
// ST_FETCH    | issuing one feature read per cycle
// ST_DRAIN    | final operand pair presented to the multiplier
// ST_WAIT_RES | waiting for the accumulated result, timeout running
// ST_DONE     | job finished, done pulses on the following cycle
module svm_mac_sched
    import svm_mac_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FEAT_AW    = FEAT_AW_DEF,
    parameter int SV_AW      = SV_AW_DEF,
    parameter int TMO_CYC    = TMO_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [FEAT_AW:0]         num_feat,
    input  logic [SV_AW:0]           num_sv,
    input  logic                     op_sel,
    output logic                     sv_rd_en,
    output logic [SV_AW+FEAT_AW-1:0] sv_rd_addr,
    input  logic [DATA_WIDTH-1:0]    sv_rd_data,
    output logic                     x_rd_en,
    output logic [FEAT_AW-1:0]       x_rd_addr,
    input  logic [DATA_WIDTH-1:0]    x_rd_data,
    output logic                     mult_en,
    output logic [DATA_WIDTH-1:0]    mult_data_1,
    output logic [DATA_WIDTH-1:0]    mult_data_2,
    output logic                     mult_op_sel,
    input  logic [DATA_WIDTH-1:0]    mult_res,
    input  logic                     mult_res_vld,
    output logic                     dot_vld,
    output logic [DATA_WIDTH-1:0]    dot_data,
    output logic [SV_AW-1:0]         dot_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     err_tmo
);

    localparam int            TW       = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
    localparam logic [TW-1:0] TMO_INC  = 1;

    state_e                  state_q, state_d;
    logic [FEAT_AW:0]        num_feat_q, num_feat_d;
    logic [SV_AW:0]          num_sv_q, num_sv_d;
    logic                    op_sel_q, op_sel_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    err_q, err_d;
    logic                    mult_en_q, mult_en_d;
    logic                    dot_vld_q, dot_vld_d;
    logic [DATA_WIDTH-1:0]   dot_data_q, dot_data_d;
    logic [SV_AW-1:0]        dot_idx_q, dot_idx_d;
    logic                    done_q, done_d;

    logic                    rd_en, clr, inc_feat, inc_sv;
    logic [FEAT_AW-1:0]      feat_idx;
    logic [SV_AW-1:0]        sv_idx;
    logic                    last_feat, last_sv;

    svm_addr_gen #(
        .FEAT_AW (FEAT_AW),
        .SV_AW   (SV_AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .inc_feat  (inc_feat),
        .inc_sv    (inc_sv),
        .num_feat  (num_feat_q),
        .num_sv    (num_sv_q),
        .feat_idx  (feat_idx),
        .sv_idx    (sv_idx),
        .last_feat (last_feat),
        .last_sv   (last_sv)
    );

    // Next-state, counter control and result capture.
    always_comb begin
        state_d    = state_q;
        num_feat_d = num_feat_q;
        num_sv_d   = num_sv_q;
        op_sel_d   = op_sel_q;
        tmo_d      = '0;
        err_d      = err_q;
        dot_vld_d  = 1'b0;
        dot_data_d = dot_data_q;
        dot_idx_d  = dot_idx_q;
        done_d     = 1'b0;
        rd_en      = 1'b0;
        clr        = 1'b0;
        inc_feat   = 1'b0;
        inc_sv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_feat_d = num_feat;
                    num_sv_d   = num_sv;
                    op_sel_d   = op_sel;
                    err_d      = 1'b0;
                    clr        = 1'b1;
                    if ((num_feat == '0) || (num_sv == '0)) state_d = ST_DONE;
                    else                                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rd_en = 1'b1;
                if (last_feat) state_d  = ST_DRAIN;
                else           inc_feat = 1'b1;
            end
            ST_DRAIN: state_d = ST_WAIT_RES;
            ST_WAIT_RES: begin
                if (mult_res_vld) begin
                    dot_vld_d  = 1'b1;
                    dot_data_d = mult_res;
                    dot_idx_d  = sv_idx;
                    if (last_sv) begin
                        state_d = ST_DONE;
                    end else begin
                        inc_sv  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_INC;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        mult_en_d = rd_en;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            num_feat_q <= '0;
            num_sv_q   <= '0;
            op_sel_q   <= 1'b0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            mult_en_q  <= 1'b0;
            dot_vld_q  <= 1'b0;
            dot_data_q <= '0;
            dot_idx_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_feat_q <= num_feat_d;
            num_sv_q   <= num_sv_d;
            op_sel_q   <= op_sel_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            mult_en_q  <= mult_en_d;
            dot_vld_q  <= dot_vld_d;
            dot_data_q <= dot_data_d;
            dot_idx_q  <= dot_idx_d;
            done_q     <= done_d;
        end
    end

    assign sv_rd_en    = rd_en;
    assign x_rd_en     = rd_en;
    assign sv_rd_addr  = {sv_idx, feat_idx};
    assign x_rd_addr   = feat_idx;
    assign mult_en     = mult_en_q;
    // Operands are gated so the multiplier bus is quiet outside valid cycles.
    assign mult_data_1 = mult_en_q ? sv_rd_data : '0;
    assign mult_data_2 = mult_en_q ? x_rd_data  : '0;
    assign mult_op_sel = op_sel_q;
    assign dot_vld     = dot_vld_q;
    assign dot_data    = dot_data_q;
    assign dot_idx     = dot_idx_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign err_tmo     = err_q;

endmodule

// File: tb/tb_svm_mac_sched.sv
// Self-checking bench for svm_mac_sched: job table, memory and MAC models,
// operand and result scoreboards, plus reset / idle-result corner sequences.
module tb_svm_mac_sched;

    localparam int DW  = 32;
    localparam int FAW = 6;
    localparam int SAW = 8;
    localparam int AW  = SAW + FAW;

    logic            clk, rst, start, op_sel;
    logic [FAW:0]    num_feat;
    logic [SAW:0]    num_sv;
    logic            sv_rd_en, x_rd_en, mult_en, mult_op_sel;
    logic [AW-1:0]   sv_rd_addr;
    logic [FAW-1:0]  x_rd_addr;
    logic [DW-1:0]   sv_rd_data, x_rd_data, mult_data_1, mult_data_2;
    logic [DW-1:0]   mult_res, dot_data;
    logic            mult_res_vld, dot_vld, busy, done, err_tmo;
    logic [SAW-1:0]  dot_idx;

    svm_mac_sched dut (
        .clk(clk), .rst(rst), .start(start), .num_feat(num_feat), .num_sv(num_sv),
        .op_sel(op_sel), .sv_rd_en(sv_rd_en), .sv_rd_addr(sv_rd_addr),
        .sv_rd_data(sv_rd_data), .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr),
        .x_rd_data(x_rd_data), .mult_en(mult_en), .mult_data_1(mult_data_1),
        .mult_data_2(mult_data_2), .mult_op_sel(mult_op_sel), .mult_res(mult_res),
        .mult_res_vld(mult_res_vld), .dot_vld(dot_vld), .dot_data(dot_data),
        .dot_idx(dot_idx), .busy(busy), .done(done), .err_tmo(err_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] sv_mem [0:(1<<AW)-1];
    logic [DW-1:0] x_mem  [0:(1<<FAW)-1];

    always @(posedge clk) begin
        if (sv_rd_en) sv_rd_data <= sv_mem[sv_rd_addr];
        if (x_rd_en)  x_rd_data  <= x_mem[x_rd_addr];
    end

    typedef struct {
        int          nf;
        int          nsv;
        bit          op;
        bit          withhold;
        bit          mid_start;
        bit          const_mem;
        int          exp_me;
        int          exp_dot;
        bit          exp_tmo;
        logic [AW-1:0] exp_last;
    } job_t;

    typedef struct packed {
        logic [DW-1:0]  d;
        logic [SAW-1:0] i;
    } dot_t;

    int errors = 0;
    int checks = 0;

    int cyc, start_cyc, done_cyc, err_cyc, last_me_cyc;
    int mult_en_cnt, rd_cnt, dot_cnt, done_cnt;
    int cur_nf, burst_len, burst_no, dly;
    bit cur_op, withhold, spur_req;
    logic [DW-1:0]   pend_res;
    logic [AW-1:0]   last_addr;
    logic [2*DW-1:0] rd_q [$];
    dot_t            dot_q [$];
    logic [AW-1:0]   addr_log [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle model: MAC result generator, operand and result scoreboards.
    task automatic mon();
        logic [2*DW-1:0] e;
        dot_t            ed;
        if (rst) begin
            rd_q.delete();
            dot_q.delete();
            burst_len    = 0;
            dly          = 0;
            mult_res_vld = 1'b0;
            return;
        end
        mult_res_vld = 1'b0;
        if (spur_req) begin
            mult_res_vld = 1'b1;
            mult_res     = 32'hBAD0_BAD0;
            spur_req     = 1'b0;
        end else if (dly != 0) begin
            dly--;
            if (dly == 0) begin
                mult_res_vld = 1'b1;
                mult_res     = pend_res;
            end
        end
        if (mult_en) begin
            mult_en_cnt++;
            last_me_cyc = cyc;
            chk("mult_op_sel", 64'(mult_op_sel), 64'(cur_op));
            if (rd_q.size() == 0) begin
                chk("mult_en_without_read", 64'(1), 64'(0));
            end else begin
                e = rd_q.pop_front();
                chk("mult_data_1", 64'(mult_data_1), 64'(e[2*DW-1:DW]));
                chk("mult_data_2", 64'(mult_data_2), 64'(e[DW-1:0]));
            end
            burst_len++;
            if (burst_len == cur_nf) begin
                if (!withhold) begin
                    pend_res = 32'hC0DE_0000 | 32'(burst_no);
                    dly      = 4;
                    dot_q.push_back('{d: pend_res, i: SAW'(burst_no)});
                end
                burst_no++;
                burst_len = 0;
            end
        end else if (burst_len != 0) begin
            chk("burst_len", 64'(burst_len), 64'(cur_nf));
            burst_len = 0;
        end
        if (sv_rd_en) begin
            rd_cnt++;
            chk("x_rd_en", 64'(x_rd_en), 64'(1));
            chk("x_rd_addr", 64'(x_rd_addr), 64'(sv_rd_addr[FAW-1:0]));
            rd_q.push_back({sv_mem[sv_rd_addr], x_mem[x_rd_addr]});
            if (addr_log.size() < 3) addr_log.push_back(sv_rd_addr);
            last_addr = sv_rd_addr;
        end
        if (dot_vld) begin
            dot_cnt++;
            if (dot_q.size() == 0) begin
                chk("dot_vld_unexpected", 64'(1), 64'(0));
            end else begin
                ed = dot_q.pop_front();
                chk("dot_data", 64'(dot_data), 64'(ed.d));
                chk("dot_idx", 64'(dot_idx), 64'(ed.i));
            end
        end
        if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = cyc;
        end
        if (err_tmo && err_cyc == 0) err_cyc = cyc;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        mon();
    endtask

    task automatic fill_mem(input bit cst);
        for (int a = 0; a < (1 << AW); a++)
            sv_mem[a] = cst ? 32'h3F80_0000 : (32'h1000_0000 | 32'(a));
        for (int f = 0; f < (1 << FAW); f++)
            x_mem[f] = cst ? 32'h4000_0000 : (32'h2000_0000 | 32'(f * 3));
    endtask

    task automatic clear_track(input job_t j);
        mult_en_cnt = 0; rd_cnt = 0; dot_cnt = 0; done_cnt = 0;
        done_cyc = 0; err_cyc = 0; last_me_cyc = 0;
        burst_len = 0; burst_no = 0; dly = 0;
        last_addr = '0;
        addr_log.delete();
        rd_q.delete();
        dot_q.delete();
        cur_nf = j.nf; cur_op = j.op; withhold = j.withhold;
    endtask

    task automatic run_job(input job_t j, input int jn);
        int n;
        fill_mem(j.const_mem);
        clear_track(j);
        tick();
        num_feat = (FAW+1)'(j.nf);
        num_sv   = (SAW+1)'(j.nsv);
        op_sel   = j.op;
        start    = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        if (j.mid_start) begin
            tick(); tick(); tick();
            chk("busy_mid_job", 64'(busy), 64'(1));
            num_feat = 7'd7; num_sv = 9'd5; op_sel = ~j.op; start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (n = 0; n < 40000 && done_cyc == 0; n++) tick();
        chk($sformatf("job%0d_done_seen", jn), 64'(done_cyc != 0), 64'(1));
        tick();
        chk($sformatf("job%0d_busy_after_done", jn), 64'(busy), 64'(0));
        chk($sformatf("job%0d_done_pulses", jn), 64'(done_cnt), 64'(1));
        chk($sformatf("job%0d_mult_en_cnt", jn), 64'(mult_en_cnt), 64'(j.exp_me));
        chk($sformatf("job%0d_rd_cnt", jn), 64'(rd_cnt), 64'(j.exp_me));
        chk($sformatf("job%0d_dot_cnt", jn), 64'(dot_cnt), 64'(j.exp_dot));
        chk($sformatf("job%0d_dot_left", jn), 64'(dot_q.size()), 64'(0));
        chk($sformatf("job%0d_err_tmo", jn), 64'(err_tmo), 64'(j.exp_tmo));
        chk($sformatf("job%0d_mult_op_sel", jn), 64'(mult_op_sel), 64'(j.op));
        if (j.exp_me != 0) begin
            chk($sformatf("job%0d_last_addr", jn), 64'(last_addr), 64'(j.exp_last));
            chk($sformatf("job%0d_addr_log_n", jn), 64'(addr_log.size()),
                64'((j.exp_me < 3) ? j.exp_me : 3));
            for (int k = 0; k < addr_log.size(); k++)
                chk($sformatf("job%0d_addr%0d", jn, k), 64'(addr_log[k]),
                    64'(((k / j.nf) << FAW) | (k % j.nf)));
        end else begin
            chk($sformatf("job%0d_zero_done_lat", jn), 64'(done_cyc - start_cyc), 64'(2));
        end
        if (j.exp_tmo) begin
            chk($sformatf("job%0d_tmo_lat", jn), 64'(err_cyc - last_me_cyc), 64'(256));
            chk($sformatf("job%0d_tmo_done", jn), 64'(done_cyc - err_cyc), 64'(1));
        end
    endtask

    job_t jobs [7];
    job_t rj;

    initial begin
        int n;
        bit hit;
        cyc = 0; rst = 1'b1; start = 1'b0; num_feat = '0; num_sv = '0; op_sel = 1'b0;
        mult_res = '0; mult_res_vld = 1'b0; spur_req = 1'b0;
        clear_track('{default: 0});

        //          nf  nsv op wh ms cm  me     dot  tmo last
        jobs[0] = '{3,   2, 0, 0, 1, 1, 6,     2,   0, {8'd1,   6'd2}};
        jobs[1] = '{1,   1, 1, 0, 0, 0, 1,     1,   0, {8'd0,   6'd0}};
        jobs[2] = '{5,   3, 1, 0, 0, 0, 15,    3,   0, {8'd2,   6'd4}};
        jobs[3] = '{2,   1, 0, 1, 0, 0, 2,     0,   1, {8'd0,   6'd1}};
        jobs[4] = '{0,   4, 1, 0, 0, 0, 0,     0,   0, {8'd0,   6'd0}};
        jobs[5] = '{4,   0, 0, 0, 0, 0, 0,     0,   0, {8'd0,   6'd0}};
        jobs[6] = '{64, 256, 0, 0, 0, 0, 16384, 256, 0, {8'd255, 6'd63}};

        fill_mem(1'b0);
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_sv_rd_en", 64'(sv_rd_en), 64'(0));
        chk("rst_x_rd_en", 64'(x_rd_en), 64'(0));
        chk("rst_mult_en", 64'(mult_en), 64'(0));
        chk("rst_addr", 64'(sv_rd_addr), 64'(0));
        chk("rst_mult_data_1", 64'(mult_data_1), 64'(0));
        chk("rst_dot_vld", 64'(dot_vld), 64'(0));
        chk("rst_dot_data", 64'(dot_data), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err_tmo", 64'(err_tmo), 64'(0));
        rst = 1'b0;
        tick();

        // A result strobe while idle must be dropped.
        spur_req = 1'b1;
        tick(); tick(); tick();
        chk("idle_res_dot_cnt", 64'(dot_cnt), 64'(0));
        chk("idle_res_busy", 64'(busy), 64'(0));

        for (int i = 0; i < 7; i++) run_job(jobs[i], i);

        // Reset while fetching the second vector, then a clean restart.
        rj = '{4, 3, 0, 0, 0, 0, 0, 0, 0, '0};
        fill_mem(1'b0);
        clear_track(rj);
        tick();
        num_feat = 7'd4; num_sv = 9'd3; op_sel = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        hit = 1'b0;
        for (n = 0; n < 200 && !hit; n++) begin
            tick();
            hit = sv_rd_en && (sv_rd_addr[AW-1:FAW] == SAW'(1));
        end
        chk("rstmid_reached_sv1", 64'(hit), 64'(1));
        rst = 1'b1;
        tick();
        chk("rstmid_sv_rd_en", 64'(sv_rd_en), 64'(0));
        chk("rstmid_x_rd_en", 64'(x_rd_en), 64'(0));
        chk("rstmid_mult_en", 64'(mult_en), 64'(0));
        chk("rstmid_busy", 64'(busy), 64'(0));
        chk("rstmid_addr", 64'(sv_rd_addr), 64'(0));
        chk("rstmid_dot_vld", 64'(dot_vld), 64'(0));
        rst = 1'b0;
        tick();
        chk("rstmid_idle_strobe", 64'(sv_rd_en), 64'(0));
        rj = '{2, 2, 1, 0, 0, 0, 4, 2, 0, {8'd1, 6'd1}};
        run_job(rj, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
